// File: rtl/screen_draw_pkg.sv
// rtl/screen_draw_pkg.sv - shared state encoding and default screen geometry for the screen drawer
package screen_draw_pkg;

    localparam int DEF_SCREEN_W = 160;
    localparam int DEF_SCREEN_H = 120;
    localparam int DEF_ADDR_W   = 15;
    localparam int DEF_COLOUR_W = 3;
    localparam int DEF_X_W      = 8;
    localparam int DEF_Y_W      = 7;

    localparam int FRAME_PIXELS = DEF_SCREEN_W * DEF_SCREEN_H;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } draw_state_t;

endpackage

// File: rtl/raster_scan_counter.sv
// rtl/raster_scan_counter.sv - raster-order x/y/linear-address counter with last-pixel flag
//
// Ports:
//   clock, reset : rising-edge clock, synchronous active-high reset
//   clear        : force x, y and addr back to the origin
//   advance      : step one pixel in raster order
//   x, y, addr   : current pixel coordinate and its linear address
//   last         : current pixel is the bottom-right one
module raster_scan_counter
    import screen_draw_pkg::*;
#(
    parameter int WIDTH  = DEF_SCREEN_W,
    parameter int HEIGHT = DEF_SCREEN_H,
    parameter int X_W    = DEF_X_W,
    parameter int Y_W    = DEF_Y_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              advance,
    output logic [X_W-1:0]    x,
    output logic [Y_W-1:0]    y,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    localparam logic [X_W-1:0] X_LAST = X_W'(WIDTH - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(HEIGHT - 1);

    logic row_end;

    assign row_end = (x == X_LAST);
    assign last    = row_end && (y == Y_LAST);

    // addr runs alongside x/y so the linear address never needs y*WIDTH+x.
    // Stepping past the last pixel returns to the origin, ready for reuse.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            x    <= '0;
            y    <= '0;
            addr <= '0;
        end else if (advance) begin
            if (last) begin
                x    <= '0;
                y    <= '0;
                addr <= '0;
            end else begin
                addr <= addr + 1'b1;
                if (row_end) begin
                    x <= '0;
                    y <= y + 1'b1;
                end else begin
                    x <= x + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/screen_draw_ctrl.sv
// rtl/screen_draw_ctrl.sv - streams a full-screen image ROM onto the VGA pixel-plot interface
//
// Ports:
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   start, img_sel, abort : frame request, image select (latched at start), cancel
//   transp_en, transp_key : skip pixels whose colour equals the key (latched at start)
//   rom_address, rom_sel  : address to both ROMs, latched image select
//   rom_q                 : selected ROM data, one cycle behind rom_address
//   vga_x, vga_y          : plot coordinate
//   vga_colour, vga_plot  : plot colour and write enable
//   busy, done            : frame in progress, one-cycle completion pulse
module screen_draw_ctrl
    import screen_draw_pkg::*;
#(
    parameter int SCREEN_W = DEF_SCREEN_W,
    parameter int SCREEN_H = DEF_SCREEN_H,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int COLOUR_W = DEF_COLOUR_W,
    parameter int X_W      = DEF_X_W,
    parameter int Y_W      = DEF_Y_W
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic                img_sel,
    input  logic                abort,
    input  logic                transp_en,
    input  logic [COLOUR_W-1:0] transp_key,
    output logic [ADDR_W-1:0]   rom_address,
    output logic                rom_sel,
    input  logic [COLOUR_W-1:0] rom_q,
    output logic [X_W-1:0]      vga_x,
    output logic [Y_W-1:0]      vga_y,
    output logic [COLOUR_W-1:0] vga_colour,
    output logic                vga_plot,
    output logic                busy,
    output logic                done
);

    draw_state_t state, state_next;

    logic                accept;
    logic                scan_advance;
    logic [X_W-1:0]      scan_x;
    logic [Y_W-1:0]      scan_y;
    logic [ADDR_W-1:0]   scan_addr;
    logic                scan_last;

    logic                pipe_valid;
    logic                transp_en_l;
    logic [COLOUR_W-1:0] transp_key_l;

    assign accept       = (state == ST_IDLE) && start;
    assign scan_advance = (state == ST_READ);

    raster_scan_counter #(
        .WIDTH  (SCREEN_W),
        .HEIGHT (SCREEN_H),
        .X_W    (X_W),
        .Y_W    (Y_W),
        .ADDR_W (ADDR_W)
    ) u_scan (
        .clock   (clock),
        .reset   (reset),
        .clear   (accept),
        .advance (scan_advance),
        .x       (scan_x),
        .y       (scan_y),
        .addr    (scan_addr),
        .last    (scan_last)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Start beats a coincident abort because abort is only looked at once busy.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_READ;
                end
            end
            ST_READ: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (scan_last) begin
                    state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Address is parked at 0 outside the scan so it can never run past the frame.
    assign rom_address = (state == ST_READ) ? scan_addr : '0;
    assign busy        = (state != ST_IDLE);
    assign done        = (state == ST_DONE);

    always_ff @(posedge clock) begin
        if (reset) begin
            rom_sel      <= 1'b0;
            transp_en_l  <= 1'b0;
            transp_key_l <= '0;
        end else if (accept) begin
            rom_sel      <= img_sel;
            transp_en_l  <= transp_en;
            transp_key_l <= transp_key;
        end
    end

    // One-cycle stage aligning the coordinate with the ROM's read latency.
    // Abort only clears the next valid; a plot already in the stage still shows.
    always_ff @(posedge clock) begin
        if (reset) begin
            pipe_valid <= 1'b0;
            vga_x      <= '0;
            vga_y      <= '0;
        end else begin
            pipe_valid <= (state == ST_READ) && !abort;
            if (state == ST_READ) begin
                vga_x <= scan_x;
                vga_y <= scan_y;
            end
        end
    end

    assign vga_colour = rom_q;
    assign vga_plot   = pipe_valid && !(transp_en_l && (rom_q == transp_key_l));

endmodule
